// File: rtl/multiplexor_pkg.sv
// Shared state encoding and mode constants for the scanning multiplexer.
package multiplexor_pkg;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        MANUAL   = 2'd1,
        BARRIDO  = 2'd2
    } estado_t;

    localparam logic MODO_MANUAL  = 1'b0;
    localparam logic MODO_BARRIDO = 1'b1;

endpackage

// File: rtl/multiplexor_barrido_contador.sv
// Dwell counter plus wrapping channel counter used by the scan mode.
module contador_barrido
    import multiplexor_pkg::*;
#(
    parameter int unsigned CANALES     = 4,
    parameter int unsigned PERMANENCIA = 4,
    parameter int unsigned SEL_W       = $clog2(CANALES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             avanzar,
    input  logic             limpiar,
    input  logic             cargar,
    input  logic [SEL_W-1:0] valor,
    output logic [SEL_W-1:0] canal,
    output logic             envuelve_c
);

    localparam int unsigned      CNT_W     = (PERMANENCIA > 1) ? $clog2(PERMANENCIA) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PERMANENCIA - 1);
    localparam logic [SEL_W-1:0] CANAL_MAX = SEL_W'(CANALES - 1);

    logic [CNT_W-1:0] permanencia;
    logic [CNT_W-1:0] base_c;
    logic             fin_perm_c;

    // A clear restarts the dwell so that this edge counts as its first cycle.
    always_comb begin
        base_c     = limpiar ? '0 : permanencia;
        fin_perm_c = avanzar && (base_c == CNT_MAX);
        envuelve_c = fin_perm_c && (canal == CANAL_MAX);
    end

    // Dwell and channel registers; load has priority over scan advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            permanencia <= '0;
            canal       <= '0;
        end else begin
            if (avanzar) begin
                permanencia <= fin_perm_c ? '0 : base_c + CNT_W'(1);
            end else begin
                permanencia <= base_c;
            end
            if (cargar) begin
                canal <= valor;
            end else if (fin_perm_c) begin
                canal <= envuelve_c ? '0 : canal + SEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/multiplexor_barrido.sv
// N-channel registered multiplexer with manual selection and automatic scan.
module multiplexor_barrido
    import multiplexor_pkg::*;
#(
    parameter int unsigned ANCHO       = 8,
    parameter int unsigned CANALES     = 4,
    parameter int unsigned PERMANENCIA = 4,
    parameter int unsigned SEL_W       = $clog2(CANALES)
) (
    input  logic                     Reloj,
    input  logic                     Reset_n,
    input  logic [CANALES*ANCHO-1:0] Entradas,
    input  logic [SEL_W-1:0]         Selector,
    input  logic                     Modo,
    input  logic                     Habilitar,
    output logic [ANCHO-1:0]         Salida,
    output logic [SEL_W-1:0]         Canal,
    output logic                     Salida_Valida,
    output logic                     Error_Sel,
    output logic                     Fin_Barrido
);

    localparam logic [SEL_W:0] CANALES_EXT = (SEL_W + 1)'(CANALES);

    estado_t          estado;
    logic [SEL_W-1:0] canal_actual;
    logic             envuelve_c;
    logic             en_manual_c;
    logic             en_barrido_c;
    logic             sel_valido_c;
    logic             limpiar_c;
    logic [ANCHO-1:0] dato_barrido_c;
    logic [ANCHO-1:0] dato_selector_c;

    // Mode decode, selector range check and dwell restart on scan entry.
    always_comb begin
        en_manual_c  = Habilitar && (Modo == MODO_MANUAL);
        en_barrido_c = Habilitar && (Modo == MODO_BARRIDO);
        sel_valido_c = {1'b0, Selector} < CANALES_EXT;
        limpiar_c    = en_manual_c || (en_barrido_c && (estado != BARRIDO));
    end

    // Channel slices for the scan channel and the requested channel.
    always_comb begin
        dato_barrido_c  = '0;
        dato_selector_c = '0;
        for (int unsigned k = 0; k < CANALES; k++) begin
            if (canal_actual == SEL_W'(k)) begin
                dato_barrido_c = Entradas[k*ANCHO +: ANCHO];
            end
            if (Selector == SEL_W'(k)) begin
                dato_selector_c = Entradas[k*ANCHO +: ANCHO];
            end
        end
    end

    contador_barrido #(
        .CANALES     (CANALES),
        .PERMANENCIA (PERMANENCIA),
        .SEL_W       (SEL_W)
    ) u_contador (
        .clk        (Reloj),
        .rst_n      (Reset_n),
        .avanzar    (en_barrido_c),
        .limpiar    (limpiar_c),
        .cargar     (en_manual_c && sel_valido_c),
        .valor      (Selector),
        .canal      (canal_actual),
        .envuelve_c (envuelve_c)
    );

    assign Canal = canal_actual;

    // Mode FSM and output register; pulses clear on every edge unless re-raised.
    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            estado        <= INACTIVO;
            Salida        <= '0;
            Salida_Valida <= 1'b0;
            Error_Sel     <= 1'b0;
            Fin_Barrido   <= 1'b0;
        end else begin
            Error_Sel   <= 1'b0;
            Fin_Barrido <= 1'b0;
            if (Habilitar) begin
                if (Modo == MODO_BARRIDO) begin
                    estado        <= BARRIDO;
                    Salida        <= dato_barrido_c;
                    Salida_Valida <= 1'b1;
                    Fin_Barrido   <= envuelve_c;
                end else begin
                    estado <= MANUAL;
                    if (sel_valido_c) begin
                        Salida        <= dato_selector_c;
                        Salida_Valida <= 1'b1;
                    end else begin
                        Error_Sel <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multiplexor_barrido.sv
// Scoreboard bench: a 4-channel/dwell-4 and a 3-channel/dwell-1 instance share stimulus.
module tb_multiplexor_barrido;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        modo;
    logic        hab;
    logic [1:0]  sel;
    logic [31:0] ent;

    logic [7:0]  sal0, sal1;
    logic [1:0]  can0, can1;
    logic        val0, val1, err0, err1, fin0, fin1;

    always #5 clk = ~clk;

    multiplexor_barrido #(.ANCHO(8), .CANALES(4), .PERMANENCIA(4)) dut0 (
        .Reloj(clk), .Reset_n(rst_n), .Entradas(ent), .Selector(sel),
        .Modo(modo), .Habilitar(hab), .Salida(sal0), .Canal(can0),
        .Salida_Valida(val0), .Error_Sel(err0), .Fin_Barrido(fin0)
    );

    multiplexor_barrido #(.ANCHO(8), .CANALES(3), .PERMANENCIA(1)) dut1 (
        .Reloj(clk), .Reset_n(rst_n), .Entradas(ent[23:0]), .Selector(sel),
        .Modo(modo), .Habilitar(hab), .Salida(sal1), .Canal(can1),
        .Salida_Valida(val1), .Error_Sel(err1), .Fin_Barrido(fin1)
    );

    typedef struct {
        logic [7:0] sal;
        logic [1:0] can;
        logic       val;
        logic       err;
        logic       fin;
    } esperado_t;

    esperado_t cola0[$];
    esperado_t cola1[$];

    int checks = 0;
    int errors = 0;

    // Reference model state per instance (index 0: 4ch/dwell 4, index 1: 3ch/dwell 1).
    int         m_canal [2];
    int         m_dwell [2];
    logic       m_scan  [2];
    logic [7:0] m_sal   [2];
    logic       m_val   [2];
    logic       m_err   [2];
    logic       m_fin   [2];

    task automatic verificar(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nombre, act, exp, $time);
        end
    endtask

    task automatic modelo_reset();
        for (int i = 0; i < 2; i++) begin
            m_canal[i] = 0; m_dwell[i] = 0; m_scan[i] = 1'b0;
            m_sal[i] = 8'h00; m_val[i] = 1'b0; m_err[i] = 1'b0; m_fin[i] = 1'b0;
        end
    endtask

    // One enabled/disabled edge of the behaviour described for the block.
    task automatic modelo_paso(input int i);
        int nch;
        int perm;
        logic [31:0] d;
        nch  = (i == 0) ? 4 : 3;
        perm = (i == 0) ? 4 : 1;
        d    = ent;
        m_err[i] = 1'b0;
        m_fin[i] = 1'b0;
        if (!hab) return;
        if (modo) begin
            if (!m_scan[i]) m_dwell[i] = 0;
            m_scan[i] = 1'b1;
            m_sal[i]  = d[8*m_canal[i] +: 8];
            m_val[i]  = 1'b1;
            m_dwell[i]++;
            if (m_dwell[i] == perm) begin
                m_dwell[i] = 0;
                if (m_canal[i] == nch - 1) begin
                    m_canal[i] = 0;
                    m_fin[i]   = 1'b1;
                end else begin
                    m_canal[i]++;
                end
            end
        end else begin
            m_scan[i]  = 1'b0;
            m_dwell[i] = 0;
            if (int'(sel) < nch) begin
                m_sal[i]   = d[8*int'(sel) +: 8];
                m_canal[i] = int'(sel);
                m_val[i]   = 1'b1;
            end else begin
                m_err[i] = 1'b1;
            end
        end
    endtask

    // Drive inputs, predict, queue expectations, then advance one clock.
    task automatic paso(input logic h, input logic m, input logic [1:0] s);
        esperado_t e;
        hab = h; modo = m; sel = s;
        if (!rst_n) modelo_reset();
        else begin
            modelo_paso(0);
            modelo_paso(1);
        end
        e.sal = m_sal[0]; e.can = 2'(m_canal[0]); e.val = m_val[0]; e.err = m_err[0]; e.fin = m_fin[0];
        cola0.push_back(e);
        e.sal = m_sal[1]; e.can = 2'(m_canal[1]); e.val = m_val[1]; e.err = m_err[1]; e.fin = m_fin[1];
        cola1.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: compare each registered output set just after the edge.
    always @(posedge clk) begin
        esperado_t e;
        #1;
        if (cola0.size() > 0) begin
            e = cola0.pop_front();
            verificar("d0_salida", 32'(sal0), 32'(e.sal));
            verificar("d0_canal",  32'(can0), 32'(e.can));
            verificar("d0_valida", 32'(val0), 32'(e.val));
            verificar("d0_error",  32'(err0), 32'(e.err));
            verificar("d0_fin",    32'(fin0), 32'(e.fin));
            verificar("d0_excl",   32'(err0 & fin0), 32'd0);
        end
        if (cola1.size() > 0) begin
            e = cola1.pop_front();
            verificar("d1_salida", 32'(sal1), 32'(e.sal));
            verificar("d1_canal",  32'(can1), 32'(e.can));
            verificar("d1_valida", 32'(val1), 32'(e.val));
            verificar("d1_error",  32'(err1), 32'(e.err));
            verificar("d1_fin",    32'(fin1), 32'(e.fin));
            verificar("d1_excl",   32'(err1 & fin1), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n = 1'b0; hab = 1'b1; modo = 1'b0; sel = 2'd0; ent = 32'hDDCC_BBAA;
        modelo_reset();
        @(negedge clk);

        // Reset held with enable high.
        for (int k = 0; k < 3; k++) paso(1'b1, 1'b0, 2'd2);
        rst_n = 1'b1;

        // Manual walk; selector 3 is out of range for the 3-channel instance.
        for (int k = 0; k < 4; k++) paso(1'b1, 1'b0, 2'(k));
        paso(1'b1, 1'b0, 2'd3);
        paso(1'b1, 1'b0, 2'd1);

        // Full scan from channel 0.
        paso(1'b1, 1'b0, 2'd0);
        for (int k = 0; k < 16; k++) paso(1'b1, 1'b1, 2'd3);

        // Freeze on the second dwell cycle of channel 1.
        for (int k = 0; k < 6; k++) paso(1'b1, 1'b1, 2'd0);
        for (int k = 0; k < 5; k++) paso(1'b0, 1'b1, 2'($urandom_range(0, 3)));
        for (int k = 0; k < 4; k++) paso(1'b1, 1'b1, 2'd0);

        // Mode switch: scan to channel 2, manual select 0, then rescan.
        guard = 0;
        while (m_canal[0] != 2 && guard < 20) begin
            paso(1'b1, 1'b1, 2'd3);
            guard++;
        end
        verificar("reach_canal2", 32'(guard < 20), 32'd1);
        paso(1'b1, 1'b0, 2'd0);
        for (int k = 0; k < 6; k++) paso(1'b1, 1'b1, 2'd1);

        // Asynchronous reset between edges in the middle of a scan.
        #3;
        rst_n = 1'b0;
        #1;
        verificar("async_rst_sal0", 32'({sal0, can0, val0, err0, fin0}), 32'd0);
        verificar("async_rst_sal1", 32'({sal1, can1, val1, err1, fin1}), 32'd0);
        modelo_reset();
        paso(1'b1, 1'b1, 2'd0);
        rst_n = 1'b1;
        paso(1'b0, 1'b1, 2'd0);
        paso(1'b1, 1'b1, 2'd0);

        // Randomized traffic with changing inputs.
        for (int k = 0; k < 400; k++) begin
            logic h;
            logic m;
            if ($urandom_range(0, 3) == 0) ent = $urandom;
            h = ($urandom_range(0, 7) != 0);
            m = ($urandom_range(0, 7) == 0) ? ~modo : modo;
            paso(h, m, 2'($urandom_range(0, 3)));
        end

        verificar("cola0_vacia", 32'(cola0.size()), 32'd0);
        verificar("cola1_vacia", 32'(cola1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiplexor_barrido.md
# multiplexor_barrido

Parametrised N-channel, W-bit multiplexer with a registered output and two selection modes: manual, where an external selector chooses the channel, and automatic scan, where an internal counter steps through every channel. It generalises the 2:1 multiplexer, which has one-bit inputs, combinational output and no defined behaviour for invalid selector codes. Typical uses are display/LED multiplexing and time-division sampling of several buses onto one.

## Interface
Parameters:
- ANCHO, 8, bit width of each channel.
- CANALES, 4, number of input channels (≥2).
- PERMANENCIA, 4, cycles spent on each channel in scan mode (≥1).
- SEL_W, $clog2(CANALES), derived; selector/channel index width.

Ports:
- Reloj  input  1  single clock; all state changes on its rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Entradas  input  CANALES*ANCHO  packed channels; channel k is bits [k*ANCHO +: ANCHO].
- Selector  input  SEL_W  channel request in manual mode.
- Modo  input  1  0 = manual, 1 = scan.
- Habilitar  input  1  1 = run, 0 = freeze all state.
- Salida  output  ANCHO  registered selected data.
- Canal  output  SEL_W  index of the channel currently driving Salida.
- Salida_Valida  output  1  Salida holds a value captured under Habilitar=1.
- Error_Sel  output  1  one-cycle pulse when a manual Selector is ≥ CANALES.
- Fin_Barrido  output  1  one-cycle pulse when scan wraps from CANALES-1 to 0.

## Operation
- FSM states: INACTIVO, MANUAL, BARRIDO.
- Reset (Reset_n=0, asynchronous): the state goes to INACTIVO. Salida=0, Canal=0, Salida_Valida=0, Error_Sel=0, Fin_Barrido=0, and the dwell counter is 0.
- INACTIVO:
  - With Habilitar=1, the next edge moves to MANUAL (Modo=0) or BARRIDO (Modo=1) and performs that state's capture on the same edge.
- MANUAL, on each edge with Habilitar=1:
  - If Selector < CANALES: Salida ← channel Selector, Canal ← Selector, Salida_Valida ← 1.
  - Otherwise: Salida and Canal hold and Error_Sel ← 1 for one cycle.
- BARRIDO, on each edge with Habilitar=1:
  - Salida ← channel Canal and the dwell counter increments.
  - When the counter reaches PERMANENCIA-1, it clears and Canal advances by 1.
  - Canal wraps CANALES-1 → 0. Fin_Barrido pulses on the edge where the wrap occurs.
  - Salida_Valida ← 1.
- Modo is sampled every enabled edge. A Modo change takes effect on that edge.
  - MANUAL → BARRIDO: scanning starts at the current Canal with the dwell counter cleared.
  - BARRIDO → MANUAL: the selector is obeyed immediately and the dwell counter clears.
- Habilitar=0:
  - All registers hold, including the dwell counter, Canal and Salida.
  - Error_Sel and Fin_Barrido are forced to 0.
  - Salida_Valida holds its value.
- Non-power-of-two CANALES: in scan mode Canal never takes a value ≥ CANALES.

## Timing
- Latency is one cycle: Entradas/Selector sampled at edge n appear on Salida/Canal after edge n.
- Entradas are sampled continuously. A channel input that changes during its dwell is reflected on the next edge.
- Scan period is CANALES*PERMANENCIA enabled cycles. Fin_Barrido fires once per period.
- With PERMANENCIA=1, Canal advances every enabled edge.
- Error_Sel and Fin_Barrido are registered, high for exactly one cycle, and never high together.
- Reset asserted mid-scan clears everything asynchronously.
- After reset releases, the first enabled edge only leaves INACTIVO and captures. No output changes before it.

## Structure
- Shared package `multiplexor_pkg` holds:
  - the state encoding (INACTIVO=2'd0, MANUAL=2'd1, BARRIDO=2'd2);
  - mode constants MODO_MANUAL=1'b0 and MODO_BARRIDO=1'b1.
- The dwell counter plus the channel counter with wrap form one natural sub-module, `contador_barrido`:
  - parameters CANALES and PERMANENCIA;
  - inputs for enable and clear;
  - outputs Canal and the wrap pulse.
- Top level contains the FSM, the output register, the selector range check, and the channel slice `Entradas[Canal*ANCHO +: ANCHO]`.

## Test plan
Defaults unless noted. Entradas = {8'hDD, 8'hCC, 8'hBB, 8'hAA} (channel 3 … channel 0).
- **Reset check:** hold Reset_n=0 with Habilitar=1 → Salida=0, Canal=0, Salida_Valida=0. Assert Reset_n=0 mid-scan between edges → all outputs 0 immediately.
- **Manual walk:** Modo=0, Habilitar=1, Selector = 0, 1, 2, 3, one per cycle → after each edge Salida = AA, BB, CC, DD, Canal = Selector, Salida_Valida=1.
- **Invalid selector (CANALES=3):** Selector=3 → Salida and Canal hold their previous values and Error_Sel is high for exactly one cycle.
- **Scan:** Modo=1 for 16 cycles → Salida sequence is AA×4, BB×4, CC×4, DD×4. Fin_Barrido pulses once, on the DD→AA wrap edge.
- **Freeze:** during scan, drop Habilitar for 5 cycles at the 2nd dwell cycle of BB → all outputs hold. After re-enable, BB persists for exactly 2 more cycles.
- **Mode switch:** scan until Canal=2, then Modo=0 with Selector=0 → next edge Salida=AA. Then Modo=1 → scan restarts from channel 0 with a full 4-cycle dwell.
